school_seating_system: RTL and testbench
========================================

SCHOOL_SEATING_SYSTEM -- requirements
Module: school_seating_system

Interface
- REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock and reset ports SHALL be named clk and rst_n.
- REQ-002 The block SHALL keep the port order clk, Student_No, Seat_No, write, Time, Seat_State, rst_n, Ack, Nack.
- REQ-003 Parameter NUM_SEATS SHALL default to 32 and set the number of seats, indexed 0..NUM_SEATS-1.
- REQ-004 Parameter AWAY_LIMIT SHALL default to 1440 and set the away timeout in clk cycles.
- REQ-005 Port list:
  - clk  in  1  rising-edge clock.
  - rst_n  in  1  asynchronous active-low reset.
  - Student_No  in  32  requesting student ID.
  - Seat_No  in  5  target seat.
  - write  in  1  request strobe, sampled on rising clk.
  - Time  out  11  remaining away cycles of seat Seat_No.
  - Seat_State  in  2  requested state: 0 FREE, 1 AWAY, 2 OCCUPIED, 3 reserved.
  - Ack  out  1  request accepted.
  - Nack  out  1  request rejected.

Function
- REQ-006 Each seat SHALL hold a state (FREE, AWAY or OCCUPIED), a 32-bit owner ID and an 11-bit away timer.
- REQ-007 A student SHALL own at most one seat at a time.
- REQ-008 Request evaluation SHALL occur on the rising clk edge when write=1, against the table state before that edge.
- REQ-009 Request 2 SHALL be accepted in two cases:
  - Seat FREE and Student_No owns no seat: seat becomes OCCUPIED and owner is set.
  - Seat already owned by Student_No (OCCUPIED or AWAY): seat becomes OCCUPIED and its timer is cleared.
  - Every other request 2 SHALL be rejected.
- REQ-010 Request 1 SHALL be accepted only when the seat is OCCUPIED and owned by Student_No; the seat becomes AWAY and its timer loads AWAY_LIMIT. Every other request 1 SHALL be rejected.
- REQ-011 Request 0 SHALL be accepted only when the seat is owned by Student_No (OCCUPIED or AWAY); the seat becomes FREE and its owner and timer are cleared. Every other request 0 SHALL be rejected.
- REQ-012 Request 3, and any Seat_No >= NUM_SEATS, SHALL be rejected.
- REQ-013 A rejected request SHALL leave the table unchanged.
- REQ-014 Ack or Nack SHALL pulse high for exactly one cycle, registered, on the edge that evaluates the request; the two SHALL never be high together, and both SHALL stay low when write=0.
- REQ-015 write held high for N edges SHALL be evaluated as N independent requests.
- REQ-016 Time SHALL be combinational from Seat_No: the seat's timer when the seat is AWAY, otherwise 0.
- REQ-017 Owner-uniqueness checks SHALL compare Student_No against all seats in parallel within a single cycle.

Reset
- REQ-018 Asserting rst_n low SHALL immediately set every seat to FREE with owner 0 and timer 0, and force Ack=0 and Nack=0.
- REQ-019 Reset asserted during a request SHALL cancel that request.
- REQ-020 Requests SHALL be evaluated starting from the first rising clk edge after rst_n deasserts.

Configuration
- REQ-021 With macro SEAT_TIMEOUT_EN defined:
  - Every AWAY timer SHALL decrement by 1 each cycle.
  - A seat whose timer is 1 SHALL become FREE on the next edge, with owner cleared.
  - A valid request to a seat on the same edge SHALL take priority over that seat's expiry.
- REQ-022 Without SEAT_TIMEOUT_EN:
  - Timers SHALL hold AWAY_LIMIT while the seat is AWAY and never expire.
  - AWAY seats SHALL persist until released or reclaimed by their owner.

Structure
- REQ-023 Package school_seating_pkg SHALL hold:
  - the seat_state_e enum (FREE=0, AWAY=1, OCCUPIED=2);
  - the seat_entry_t struct (state, owner, timer);
  - the default constants NUM_SEATS_DEF=32 and AWAY_LIMIT_DEF=1440.
- REQ-024 Sub-module seat_timer SHALL implement one seat's away countdown and expiry flag, and SHALL be instantiated NUM_SEATS times.

Verification
- REQ-025 Student 201819186 requests seat 1, state 2 -> Ack; seat 1 OCCUPIED with owner 201819186.
- REQ-026 Student 201912352 takes seat 2 (state 2, Ack), then requests state 1 -> Ack; Time with Seat_No=2 reads 1440, then counts down by 1 per cycle.
- REQ-027 Student 201918757 takes seat 5 (Ack), repeats seat 5 state 2 -> Ack with no change; then requests seat 3 state 2 -> Nack; seat 3 stays FREE.
- REQ-028 Student 201912379 requests seat 1 (owned by 201819186) -> Nack; then 201819186 requests seat 1 state 0 -> Ack; seat 1 FREE.
- REQ-029 With SEAT_TIMEOUT_EN, seat 2 AWAY with no further requests -> seat 2 FREE 1440 cycles later and Time reads 0; a request from 201912352 for seat 2 state 2 is then accepted as a new claim.
- REQ-030 rst_n pulsed low while seats 2 and 5 are held -> all seats FREE immediately; Ack=0, Nack=0 and Time=0 for every Seat_No.

Source files
------------

// File: rtl/school_seating_pkg.sv
// Shared types and default sizing for the school seating table.
package school_seating_pkg;
    localparam int unsigned NUM_SEATS_DEF  = 32;
    localparam int unsigned AWAY_LIMIT_DEF = 1440;
    localparam int unsigned ID_W           = 32;
    localparam int unsigned SEAT_W         = 5;
    localparam int unsigned TIME_W         = 11;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        AWAY     = 2'd1,
        OCCUPIED = 2'd2
    } seat_state_e;

    typedef struct packed {
        seat_state_e       state;
        logic [ID_W-1:0]   owner;
        logic [TIME_W-1:0] timer;
    } seat_entry_t;
endpackage

// File: rtl/school_seating_system_if.sv
// Request/response bundle of the seating table; master drives requests, slave answers.
interface school_seating_system_if
    import school_seating_pkg::*;
    ();
    logic [ID_W-1:0]   Student_No;
    logic [SEAT_W-1:0] Seat_No;
    logic              write;
    logic [1:0]        Seat_State;
    logic [TIME_W-1:0] Time;
    logic              Ack;
    logic              Nack;

    modport master (output Student_No, Seat_No, write, Seat_State,
                    input  Time, Ack, Nack);
    modport slave  (input  Student_No, Seat_No, write, Seat_State,
                    output Time, Ack, Nack);
endinterface

// File: rtl/school_seating_system_seat_timer.sv
// One seat's away countdown; counts down and flags expiry only with SEAT_TIMEOUT_EN.
module seat_timer
    import school_seating_pkg::*;
#(
    parameter int unsigned AWAY_LIMIT = AWAY_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic              away_i,
    output logic [TIME_W-1:0] timer_o,
    output logic              expire_o
);
    logic [TIME_W-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q;
        if (clr_i) begin
            timer_d = '0;
        end else if (load_i) begin
            timer_d = TIME_W'(AWAY_LIMIT);
        end else if (away_i) begin
`ifdef SEAT_TIMEOUT_EN
            if (timer_q != '0) timer_d = timer_q - 1'b1;
`else
            timer_d = TIME_W'(AWAY_LIMIT);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timer_q <= '0;
        else        timer_q <= timer_d;
    end

    assign timer_o = timer_q;
`ifdef SEAT_TIMEOUT_EN
    assign expire_o = away_i && (timer_q == TIME_W'(1));
`else
    assign expire_o = 1'b0;
`endif
endmodule

// File: rtl/school_seating_system.sv
// Seat reservation table with registered Ack/Nack; away-seat expiry is enabled by
// defining SEAT_TIMEOUT_EN (default build: AWAY seats never expire).
module school_seating_system
    import school_seating_pkg::*;
#(
    parameter int unsigned NUM_SEATS  = NUM_SEATS_DEF,
    parameter int unsigned AWAY_LIMIT = AWAY_LIMIT_DEF
) (
    input  logic              clk,
    input  logic [ID_W-1:0]   Student_No,
    input  logic [SEAT_W-1:0] Seat_No,
    input  logic              write,
    output logic [TIME_W-1:0] Time,
    input  logic [1:0]        Seat_State,
    input  logic              rst_n,
    output logic              Ack,
    output logic              Nack
);
    seat_state_e       state_q [NUM_SEATS];
    seat_state_e       state_d [NUM_SEATS];
    logic [ID_W-1:0]   owner_q [NUM_SEATS];
    logic [ID_W-1:0]   owner_d [NUM_SEATS];
    logic [TIME_W-1:0] timer_w [NUM_SEATS];
    logic [NUM_SEATS-1:0] hit, owned_by_req, load, clr, expire;
    seat_entry_t cur;
    logic seat_ok, owns_any, cur_owned, accept;
    logic ack_q, ack_d, nack_q, nack_d;

    if (NUM_SEATS >= (1 << SEAT_W)) begin : g_full_range
        assign seat_ok = 1'b1;
    end else begin : g_part_range
        assign seat_ok = (Seat_No < SEAT_W'(NUM_SEATS));
    end

    // Owner match is evaluated against every seat at once to enforce one seat per student.
    always_comb begin
        cur = '0;
        for (int unsigned i = 0; i < NUM_SEATS; i++) begin
            hit[i]          = (32'(Seat_No) == i);
            owned_by_req[i] = (state_q[i] != FREE) && (owner_q[i] == Student_No);
            if (hit[i]) cur = '{state: state_q[i], owner: owner_q[i], timer: timer_w[i]};
        end
        owns_any  = |owned_by_req;
        cur_owned = (cur.state != FREE) && (cur.owner == Student_No);
        case (Seat_State)
            2'd2:    accept = cur_owned || ((cur.state == FREE) && !owns_any);
            2'd1:    accept = cur_owned && (cur.state == OCCUPIED);
            2'd0:    accept = cur_owned;
            default: accept = 1'b0;
        endcase
        accept = accept && write && seat_ok;
        ack_d  = accept;
        nack_d = write && !accept;
        Time   = (cur.state == AWAY) ? cur.timer : '0;
    end

    // An accepted request on a seat overrides that seat's expiry on the same edge.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SEATS; i++) begin
            state_d[i] = state_q[i];
            owner_d[i] = owner_q[i];
            load[i]    = 1'b0;
            clr[i]     = 1'b0;
            if (accept && hit[i]) begin
                case (Seat_State)
                    2'd2: begin
                        state_d[i] = OCCUPIED;
                        owner_d[i] = Student_No;
                        clr[i]     = 1'b1;
                    end
                    2'd1: begin
                        state_d[i] = AWAY;
                        load[i]    = 1'b1;
                    end
                    default: begin
                        state_d[i] = FREE;
                        owner_d[i] = '0;
                        clr[i]     = 1'b1;
                    end
                endcase
            end else if (expire[i]) begin
                state_d[i] = FREE;
                owner_d[i] = '0;
                clr[i]     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_SEATS; i++) begin
                state_q[i] <= FREE;
                owner_q[i] <= '0;
            end
            ack_q  <= 1'b0;
            nack_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_SEATS; i++) begin
                state_q[i] <= state_d[i];
                owner_q[i] <= owner_d[i];
            end
            ack_q  <= ack_d;
            nack_q <= nack_d;
        end
    end

    for (genvar g = 0; g < NUM_SEATS; g++) begin : g_seat
        seat_timer #(.AWAY_LIMIT(AWAY_LIMIT)) u_timer (
            .clk      (clk),
            .rst_n    (rst_n),
            .load_i   (load[g]),
            .clr_i    (clr[g]),
            .away_i   (state_q[g] == AWAY),
            .timer_o  (timer_w[g]),
            .expire_o (expire[g])
        );
    end

    assign Ack  = ack_q;
    assign Nack = nack_q;
endmodule

// File: tb/tb_school_seating_system.sv
// Directed bench for school_seating_system with a rule-level seat model checked every cycle.
module tb_school_seating_system;
    localparam int LIMIT = 1440;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    school_seating_system_if bus ();

    school_seating_system #(.NUM_SEATS(32), .AWAY_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .Student_No (bus.Student_No),
        .Seat_No    (bus.Seat_No),
        .write      (bus.write),
        .Time       (bus.Time),
        .Seat_State (bus.Seat_State),
        .rst_n      (rst_n),
        .Ack        (bus.Ack),
        .Nack       (bus.Nack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: seat state 0 free / 1 away / 2 occupied, owner and remaining away time.
    int          m_state [32];
    logic [31:0] m_owner [32];
    int          m_timer [32];
    bit          exp_ack, exp_nack;
    int          s;
    bit          acc, owned, owns_any;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_state[i] = 0; m_owner[i] = 0; m_timer[i] = 0;
            end
            exp_ack = 0; exp_nack = 0;
        end else begin
            s = int'(bus.Seat_No);
            acc = 0;
            if (bus.write) begin
                owns_any = 0;
                for (int i = 0; i < 32; i++)
                    if (m_state[i] != 0 && m_owner[i] == bus.Student_No) owns_any = 1;
                owned = (m_state[s] != 0) && (m_owner[s] == bus.Student_No);
                case (int'(bus.Seat_State))
                    2: acc = owned || (m_state[s] == 0 && !owns_any);
                    1: acc = owned && m_state[s] == 2;
                    0: acc = owned;
                    default: acc = 0;
                endcase
            end
`ifdef SEAT_TIMEOUT_EN
            for (int i = 0; i < 32; i++) begin
                if (m_state[i] == 1 && !(acc && i == s)) begin
                    if (m_timer[i] == 1) begin
                        m_state[i] = 0; m_owner[i] = 0; m_timer[i] = 0;
                    end else begin
                        m_timer[i] = m_timer[i] - 1;
                    end
                end
            end
`endif
            if (acc) begin
                case (int'(bus.Seat_State))
                    2: begin m_state[s] = 2; m_owner[s] = bus.Student_No; m_timer[s] = 0; end
                    1: begin m_state[s] = 1; m_timer[s] = LIMIT; end
                    default: begin m_state[s] = 0; m_owner[s] = 0; m_timer[s] = 0; end
                endcase
            end
            exp_ack  = bus.write && acc;
            exp_nack = bus.write && !acc;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("model_ack", bus.Ack, exp_ack);
            chk("model_nack", bus.Nack, exp_nack);
            chk("ack_nack_exclusive", bus.Ack & bus.Nack, 0);
            chk("model_time", bus.Time,
                (m_state[bus.Seat_No] == 1) ? m_timer[bus.Seat_No] : 0);
        end
    end

    // Called just after a rising edge; issues one request and checks the response.
    task automatic req(input logic [31:0] id, input int seat, input int st,
                       input bit ack, input string name);
        bus.Student_No = id;
        bus.Seat_No    = 5'(seat);
        bus.Seat_State = 2'(st);
        bus.write      = 1'b1;
        @(posedge clk); #2;
        bus.write = 1'b0;
        chk({name, "_ack"}, bus.Ack, ack);
        chk({name, "_nack"}, bus.Nack, !ack);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        bus.Student_No = '0; bus.Seat_No = '0; bus.Seat_State = '0; bus.write = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_ack", bus.Ack, 0);
        chk("reset_nack", bus.Nack, 0);
        chk("reset_time", bus.Time, 0);
        rst_n = 1'b1;

        req(201819186, 1, 2, 1, "s1_claim");
        req(201912352, 2, 2, 1, "s2_claim");
        req(201912352, 2, 1, 1, "s2_away");
        chk("s2_time_load", bus.Time, 1440);
        for (int k = 1; k <= 3; k++) begin
            tick(1);
`ifdef SEAT_TIMEOUT_EN
            chk("s2_time_count", bus.Time, 11'(1440 - k));
`else
            chk("s2_time_hold", bus.Time, 1440);
`endif
        end
        tick(1436);
`ifdef SEAT_TIMEOUT_EN
        chk("s2_time_last", bus.Time, 1);
        tick(1);
        chk("s2_time_expired", bus.Time, 0);
`else
        chk("s2_time_persist", bus.Time, 1440);
        tick(1);
        chk("s2_time_persist2", bus.Time, 1440);
`endif
        req(201912352, 2, 2, 1, "s2_reclaim");
        chk("s2_time_cleared", bus.Time, 0);

        req(201918757, 5, 2, 1, "s5_claim");
        req(201918757, 5, 2, 1, "s5_repeat");
        req(201918757, 3, 2, 0, "s3_second_seat");
        req(777, 3, 2, 1, "s3_free_claim");
        req(777, 3, 0, 1, "s3_release");

        req(201912379, 1, 2, 0, "s1_taken");
        req(201819186, 1, 0, 1, "s1_release");
        req(201819186, 1, 0, 0, "s1_release_free");

        bus.Student_No = 55; bus.Seat_No = 5'd7; bus.Seat_State = 2'd2; bus.write = 1'b1;
        tick(1); chk("held_claim1", bus.Ack, 1);
        tick(1); chk("held_claim2", bus.Ack, 1);
        bus.Seat_State = 2'd0;
        tick(1); chk("held_rel1", bus.Ack, 1);
        tick(1); chk("held_rel2_nack", bus.Nack, 1);
        bus.write = 1'b0;
        tick(1); chk("idle_ack", bus.Ack, 0); chk("idle_nack", bus.Nack, 0);

        req(55, 7, 2, 1, "s7_claim");
        req(55, 7, 1, 1, "s7_away");
        req(55, 7, 1, 0, "s7_away_again");
        req(66, 7, 2, 0, "s7_other");
        req(55, 8, 2, 0, "s8_owner_has_seat");
        req(55, 7, 3, 0, "s7_reserved");
        req(55, 7, 0, 1, "s7_release_away");

        bus.Student_No = 201912379; bus.Seat_No = 5'd9; bus.Seat_State = 2'd2; bus.write = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ack", bus.Ack, 0);
        chk("rst_nack", bus.Nack, 0);
        for (int i = 0; i < 32; i++) begin
            bus.Seat_No = 5'(i);
            #1 chk("rst_time", bus.Time, 0);
        end
        @(posedge clk); #2;
        bus.write = 1'b0;
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_ack", bus.Ack, 0);
        chk("post_rst_nack", bus.Nack, 0);
        req(201918757, 3, 2, 1, "post_rst_claim");
        req(201912352, 2, 0, 0, "post_rst_s2_free");
        req(201912379, 9, 2, 1, "post_rst_cancelled");

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
